sram_readback_engine: RTL and testbench

//  Read-side counterpart of byte-wise SRAM programming. Reads synaptic words
//  (32b) or neuron state words (128b) over a burst and streams them out one

---
 rtl/readback_pkg.sv | 31 +++
 rtl/rb_word_serializer.sv | 46 ++++
 rtl/sram_readback_engine.sv | 187 ++++++++++++++++++
 tb/tb_sram_readback_engine.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/readback_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : readback_pkg
//  Purpose  : Shared types and constants for the SRAM readback engine:
//             burst state encoding, per-word byte counts, address and
//             count widths, and the last-byte-index helper.
//  Revision : 1.0  initial release
// ============================================================================
package readback_pkg;

    // Burst sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        EMIT = 2'd3
    } rb_state_t;

    localparam int SYN_BYTES  = 4;
    localparam int NEUR_BYTES = 16;
    localparam int SYN_AW     = 13;
    localparam int CNT_W      = 14;
    localparam int IDX_W      = 4;

    // Index of the final byte of a word for the selected memory
    function automatic logic [IDX_W-1:0] last_index(input logic neur_sel);
        return neur_sel ? IDX_W'(NEUR_BYTES - 1) : IDX_W'(SYN_BYTES - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rb_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : rb_word_serializer
//  Purpose  : Holds one fetched SRAM word (synaptic words zero-extended to
//             128 bits) and presents it one byte at a time, LSB byte first.
//             Flags the final byte of the word for the selected memory.
//  Revision : 1.0  initial release
// ============================================================================
module rb_word_serializer
    import readback_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_neur_sel,
    input  logic [31:0]  i_syn_word,
    input  logic [127:0] i_neur_word,
    input  logic         i_advance,
    output logic [7:0]   o_byte,
    output logic         o_last_byte
);

    logic [127:0]     r_word;
    logic [IDX_W-1:0] r_idx;
    logic             r_neur;

    // Capture a new word with index 0, or step the byte index on each accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_idx  <= '0;
            r_neur <= 1'b0;
        end else if (i_load) begin
            r_word <= i_neur_sel ? i_neur_word : {96'h0, i_syn_word};
            r_idx  <= '0;
            r_neur <= i_neur_sel;
        end else if (i_advance) begin
            r_idx  <= o_last_byte ? '0 : r_idx + 1'b1;
        end
    end

    assign o_byte      = r_word[{r_idx, 3'b000} +: 8];
    assign o_last_byte = (r_idx == last_index(r_neur));

endmodule
`default_nettype wire

// File: rtl/sram_readback_engine.sv
`default_nettype none
// ============================================================================
//  Module   : sram_readback_engine
//  Purpose  : Burst reader for the synaptic (32b) or neuron-state (128b)
//             SRAM. Each word is fetched with a one-cycle select, captured
//             the following cycle, then streamed out byte by byte with a
//             valid/ready handshake. Addresses wrap per memory size.
//  Options  : READBACK_CHECKSUM_EN - enables the running 16-bit byte sum on
//             CHECKSUM; when undefined CHECKSUM is constant zero.
//  Revision : 1.0  initial release
// ============================================================================
module sram_readback_engine
    import readback_pkg::*;
#(
    parameter int N = 256,
    parameter int M = 8
) (
    input  logic              CLK,
    input  logic              RST_sync,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_MEM_SEL,
    input  logic [SYN_AW-1:0] REQ_ADDR,
    input  logic [CNT_W-1:0]  REQ_COUNT,
    input  logic              ABORT,
    output logic              RB_SYNARRAY_CS,
    output logic [SYN_AW-1:0] RB_SYNARRAY_ADDR,
    input  logic [31:0]       SYNARRAY_RDATA,
    output logic              RB_NEURMEM_CS,
    output logic [M-1:0]      RB_NEURMEM_ADDR,
    input  logic [127:0]      NEUR_STATE,
    output logic [7:0]        BYTE_DATA,
    output logic              BYTE_VALID,
    input  logic              BYTE_READY,
    output logic              BYTE_LAST,
    output logic              BUSY,
    output logic              DONE,
    output logic [15:0]       CHECKSUM
);

    rb_state_t         r_state;
    logic              r_neur_sel;
    logic [SYN_AW-1:0] r_syn_addr;
    logic [M-1:0]      r_neur_addr;
    logic [CNT_W-1:0]  r_words_left;
    logic              r_syn_cs;
    logic              r_neur_cs;
    logic              r_byte_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_req_ready;

    logic              w_req_accept;
    logic              w_byte_accept;
    logic              w_last_byte;
    logic              w_final_word;
    logic              w_word_done;
    logic [M-1:0]      w_neur_addr_next;
    logic [7:0]        w_byte;

    assign w_req_accept     = REQ_VALID & r_req_ready;
    assign w_byte_accept    = r_byte_valid & BYTE_READY;
    assign w_final_word     = (r_words_left == CNT_W'(1));
    assign w_word_done      = w_byte_accept & w_last_byte;
    assign w_neur_addr_next = (r_neur_addr == M'(N - 1)) ? '0 : r_neur_addr + 1'b1;

    // Burst sequencer: request accept, select pulse, capture, byte emission
    always_ff @(posedge CLK) begin
        if (RST_sync) begin
            r_state      <= IDLE;
            r_neur_sel   <= 1'b0;
            r_syn_addr   <= '0;
            r_neur_addr  <= '0;
            r_words_left <= '0;
            r_syn_cs     <= 1'b0;
            r_neur_cs    <= 1'b0;
            r_byte_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_req_ready  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (ABORT && (r_state != IDLE)) begin
                r_state      <= IDLE;
                r_syn_cs     <= 1'b0;
                r_neur_cs    <= 1'b0;
                r_byte_valid <= 1'b0;
                r_busy       <= 1'b0;
                r_req_ready  <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_req_accept) begin
                            r_neur_sel   <= REQ_MEM_SEL;
                            r_syn_addr   <= REQ_ADDR;
                            r_neur_addr  <= REQ_ADDR[M-1:0];
                            r_words_left <= REQ_COUNT;
                            if (REQ_COUNT == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state     <= READ;
                                r_syn_cs    <= ~REQ_MEM_SEL;
                                r_neur_cs   <= REQ_MEM_SEL;
                                r_busy      <= 1'b1;
                                r_req_ready <= 1'b0;
                            end
                        end
                    end
                    READ: begin
                        r_state   <= WAIT;
                        r_syn_cs  <= 1'b0;
                        r_neur_cs <= 1'b0;
                    end
                    WAIT: begin
                        r_state      <= EMIT;
                        r_byte_valid <= 1'b1;
                    end
                    EMIT: begin
                        if (w_word_done) begin
                            r_byte_valid <= 1'b0;
                            if (w_final_word) begin
                                r_state     <= IDLE;
                                r_busy      <= 1'b0;
                                r_req_ready <= 1'b1;
                                r_done      <= 1'b1;
                            end else begin
                                r_state      <= READ;
                                r_words_left <= r_words_left - 1'b1;
                                r_syn_addr   <= r_syn_addr + 1'b1;
                                r_neur_addr  <= w_neur_addr_next;
                                r_syn_cs     <= ~r_neur_sel;
                                r_neur_cs    <= r_neur_sel;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    rb_word_serializer u_serializer (
        .clk         (CLK),
        .rst         (RST_sync),
        .i_load      (r_state == WAIT),
        .i_neur_sel  (r_neur_sel),
        .i_syn_word  (SYNARRAY_RDATA),
        .i_neur_word (NEUR_STATE),
        .i_advance   (w_byte_accept),
        .o_byte      (w_byte),
        .o_last_byte (w_last_byte)
    );

`ifdef READBACK_CHECKSUM_EN
    logic [15:0] r_checksum;

    // Running sum of accepted bytes, restarted on every accepted request
    always_ff @(posedge CLK) begin
        if (RST_sync) begin
            r_checksum <= '0;
        end else if (w_req_accept) begin
            r_checksum <= '0;
        end else if (w_byte_accept) begin
            r_checksum <= r_checksum + {8'h00, w_byte};
        end
    end

    assign CHECKSUM = r_checksum;
`else
    assign CHECKSUM = 16'h0000;
`endif

    assign REQ_READY        = r_req_ready;
    assign RB_SYNARRAY_CS   = r_syn_cs;
    assign RB_SYNARRAY_ADDR = r_syn_addr;
    assign RB_NEURMEM_CS    = r_neur_cs;
    assign RB_NEURMEM_ADDR  = r_neur_addr;
    assign BYTE_DATA        = w_byte;
    assign BYTE_VALID       = r_byte_valid;
    assign BYTE_LAST        = r_byte_valid & w_last_byte & w_final_word;
    assign BUSY             = r_busy;
    assign DONE             = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sram_readback_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_readback_engine
//  Purpose  : Self-checking bench for sram_readback_engine. Memory contents
//             are modelled as arrays; each accepted request is expanded into
//             the expected address and byte streams, and a per-cycle monitor
//             compares the DUT handshake, selects, DONE/BUSY and CHECKSUM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_readback_engine;

    localparam int N = 256;
    localparam int M = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_mem_sel;
    logic [12:0]  req_addr;
    logic [13:0]  req_count;
    logic         abort_i;
    logic         byte_ready;
    logic [31:0]  syn_rdata;
    logic [127:0] neur_rdata;

    logic         REQ_READY;
    logic         RB_SYNARRAY_CS;
    logic [12:0]  RB_SYNARRAY_ADDR;
    logic         RB_NEURMEM_CS;
    logic [M-1:0] RB_NEURMEM_ADDR;
    logic [7:0]   BYTE_DATA;
    logic         BYTE_VALID;
    logic         BYTE_LAST;
    logic         BUSY;
    logic         DONE;
    logic [15:0]  CHECKSUM;

    logic [31:0]  syn_mem  [0:8191];
    logic [127:0] neur_mem [0:255];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // model state
    logic [7:0] exp_bytes[$];
    int         exp_syn_addr[$];
    int         exp_neur_addr[$];
    bit         m_busy     = 1'b0;
    bit         m_neur     = 1'b0;
    int         m_done_cyc = -1;
    logic [15:0] m_sum     = 16'h0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    // observations for directed checks
    logic [7:0] got_bytes[$];
    bit         got_last[$];
    int         cs_addrs[$];
    int         cs_count      = 0;
    int         t_acc         = -1;
    int         t_first_cs    = -1;
    int         t_first_valid = -1;
    int         t_done        = -1;

    int           a;
    logic [127:0] word;
    logic [7:0]   e;

    sram_readback_engine #(.N(N), .M(M)) dut (
        .CLK              (clk),
        .RST_sync         (rst),
        .REQ_VALID        (req_valid),
        .REQ_READY        (REQ_READY),
        .REQ_MEM_SEL      (req_mem_sel),
        .REQ_ADDR         (req_addr),
        .REQ_COUNT        (req_count),
        .ABORT            (abort_i),
        .RB_SYNARRAY_CS   (RB_SYNARRAY_CS),
        .RB_SYNARRAY_ADDR (RB_SYNARRAY_ADDR),
        .SYNARRAY_RDATA   (syn_rdata),
        .RB_NEURMEM_CS    (RB_NEURMEM_CS),
        .RB_NEURMEM_ADDR  (RB_NEURMEM_ADDR),
        .NEUR_STATE       (neur_rdata),
        .BYTE_DATA        (BYTE_DATA),
        .BYTE_VALID       (BYTE_VALID),
        .BYTE_READY       (byte_ready),
        .BYTE_LAST        (BYTE_LAST),
        .BUSY             (BUSY),
        .DONE             (DONE),
        .CHECKSUM         (CHECKSUM)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read SRAMs: data appears the cycle after the select
    always @(posedge clk) begin
        if (RB_SYNARRAY_CS) syn_rdata  <= syn_mem[RB_SYNARRAY_ADDR];
        if (RB_NEURMEM_CS)  neur_rdata <= neur_mem[RB_NEURMEM_ADDR];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // per-cycle comparison against the burst model
    always @(negedge clk) begin
        if (rst) begin
            exp_bytes.delete();
            exp_syn_addr.delete();
            exp_neur_addr.delete();
            m_busy     = 1'b0;
            m_done_cyc = -1;
            m_sum      = 16'h0;
            prev_stall = 1'b0;
        end else begin
`ifdef READBACK_CHECKSUM_EN
            check("checksum", CHECKSUM, m_sum);
`else
            check("checksum_zero", CHECKSUM, 16'h0);
`endif
            check("busy", BUSY, m_busy);
            check("req_ready", REQ_READY, !m_busy);
            check("done", DONE, cyc == m_done_cyc);
            if (DONE && t_done < 0) t_done = cyc;
            if (!m_busy) check("valid_when_idle", BYTE_VALID, 1'b0);
            if (prev_stall) begin
                check("stall_valid", BYTE_VALID, 1'b1);
                check("stall_data", BYTE_DATA, prev_data);
                check("stall_last", BYTE_LAST, prev_last);
            end
            check("cs_exclusive", RB_SYNARRAY_CS & RB_NEURMEM_CS, 1'b0);
            if (RB_SYNARRAY_CS) begin
                cs_count++;
                cs_addrs.push_back(int'(RB_SYNARRAY_ADDR));
                if (t_first_cs < 0) t_first_cs = cyc;
                if (m_neur || exp_syn_addr.size() == 0) check("syn_cs_unexpected", 1'b1, 1'b0);
                else check("syn_addr", RB_SYNARRAY_ADDR, exp_syn_addr.pop_front());
            end
            if (RB_NEURMEM_CS) begin
                cs_count++;
                cs_addrs.push_back(int'(RB_NEURMEM_ADDR));
                if (t_first_cs < 0) t_first_cs = cyc;
                if (!m_neur || exp_neur_addr.size() == 0) check("neur_cs_unexpected", 1'b1, 1'b0);
                else check("neur_addr", RB_NEURMEM_ADDR, exp_neur_addr.pop_front());
            end
            if (BYTE_VALID && t_first_valid < 0) t_first_valid = cyc;
            if (BYTE_VALID && byte_ready) begin
                got_bytes.push_back(BYTE_DATA);
                got_last.push_back(BYTE_LAST);
                if (exp_bytes.size() == 0) begin
                    check("byte_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_bytes.pop_front();
                    check("byte_data", BYTE_DATA, e);
                    check("byte_last", BYTE_LAST, exp_bytes.size() == 0);
                    m_sum = m_sum + {8'h00, e};
                    if (exp_bytes.size() == 0) begin
                        m_busy     = 1'b0;
                        m_done_cyc = cyc + 1;
                    end
                end
            end
            prev_stall = BYTE_VALID && !byte_ready && !abort_i;
            prev_data  = BYTE_DATA;
            prev_last  = BYTE_LAST;
            if (abort_i && m_busy) begin
                m_busy = 1'b0;
                exp_bytes.delete();
                exp_syn_addr.delete();
                exp_neur_addr.delete();
                prev_stall = 1'b0;
            end
            if (req_valid && REQ_READY) begin
                t_acc  = cyc;
                m_sum  = 16'h0;
                m_neur = req_mem_sel;
                for (int w = 0; w < int'(req_count); w++) begin
                    if (req_mem_sel) begin
                        a = (int'(req_addr[7:0]) + w) % N;
                        exp_neur_addr.push_back(a);
                        word = neur_mem[a];
                        for (int k = 0; k < 16; k++) exp_bytes.push_back(word[8*k +: 8]);
                    end else begin
                        a = (int'(req_addr) + w) % 8192;
                        exp_syn_addr.push_back(a);
                        word = {96'h0, syn_mem[a]};
                        for (int k = 0; k < 4; k++) exp_bytes.push_back(word[8*k +: 8]);
                    end
                end
                if (req_count == 14'd0) m_done_cyc = cyc + 1;
                else m_busy = 1'b1;
            end
        end
    end

    task automatic start_burst(input logic sel, input logic [12:0] addr, input logic [13:0] count);
        @(posedge clk); #1;
        got_bytes.delete();
        got_last.delete();
        cs_addrs.delete();
        cs_count      = 0;
        t_acc         = -1;
        t_first_cs    = -1;
        t_first_valid = -1;
        t_done        = -1;
        req_valid     = 1'b1;
        req_mem_sel   = sel;
        req_addr      = addr;
        req_count     = count;
        @(posedge clk); #1;
        req_valid     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while (t_done < 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (t_done < 0) check({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic wait_bytes(input string name, input int count, input int limit);
        int n;
        n = 0;
        while (got_bytes.size() < count && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (got_bytes.size() < count) check({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_mem_sel = 1'b0;
        req_addr    = '0;
        req_count   = '0;
        abort_i     = 1'b0;
        byte_ready  = 1'b1;
        for (int i = 0; i < 8192; i++) syn_mem[i] = 32'h9E37_0000 ^ (i * 32'h0001_0203);
        for (int i = 0; i < 256; i++)  neur_mem[i] = {4{32'h5A00_0000 + i * 32'h0102_0304}};
        syn_mem[13'h0041] = 32'hA1B2C3D4;
        syn_mem[13'h0042] = 32'h11223344;
        syn_mem[13'h1FFF] = 32'hCAFEF00D;
        syn_mem[13'h0000] = 32'h01234567;
        neur_mem[8]   = 128'h0F0E0D0C0B0A09080706050403020100;
        neur_mem[255] = 128'hFFEEDDCCBBAA99887766554433221100;
        neur_mem[0]   = 128'h00112233445566778899AABBCCDDEEFF;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", REQ_READY, 1'b1);
        check("rst_busy", BUSY, 1'b0);
        check("rst_valid", BYTE_VALID, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_syn_cs", RB_SYNARRAY_CS, 1'b0);
        check("rst_neur_cs", RB_NEURMEM_CS, 1'b0);
        check("rst_byte_data", BYTE_DATA, 8'h00);
        check("rst_checksum", CHECKSUM, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // synaptic burst of two words
        start_burst(1'b0, 13'h0041, 14'd2);
        wait_done("syn2", 200);
        check("syn2_cs_latency", t_first_cs - t_acc, 1);
        check("syn2_valid_latency", t_first_valid - t_acc, 3);
        check("syn2_cs_count", cs_count, 2);
        check("syn2_first_addr", cs_addrs[0], 32'h41);
        check("syn2_nbytes", got_bytes.size(), 8);
        check("syn2_b0", got_bytes[0], 8'hD4);
        check("syn2_b1", got_bytes[1], 8'hC3);
        check("syn2_b2", got_bytes[2], 8'hB2);
        check("syn2_b3", got_bytes[3], 8'hA1);
        check("syn2_b7", got_bytes[7], 8'h11);
        check("syn2_last6", got_last[6], 1'b0);
        check("syn2_last7", got_last[7], 1'b1);

        // single-word checksum
        start_burst(1'b0, 13'h0041, 14'd1);
        wait_done("cksum", 200);
        @(negedge clk);
`ifdef READBACK_CHECKSUM_EN
        check("cksum_value", CHECKSUM, 16'h02EA);
`else
        check("cksum_value", CHECKSUM, 16'h0000);
`endif

        // neuron burst, ascending bytes
        start_burst(1'b1, 13'h0008, 14'd1);
        wait_done("neur1", 300);
        check("neur1_addr", cs_addrs[0], 8);
        check("neur1_nbytes", got_bytes.size(), 16);
        check("neur1_b0", got_bytes[0], 8'h00);
        check("neur1_b15", got_bytes[15], 8'h0F);
        check("neur1_last14", got_last[14], 1'b0);
        check("neur1_last15", got_last[15], 1'b1);

        // backpressure on byte 2 for five cycles
        start_burst(1'b0, 13'h0041, 14'd2);
        wait_bytes("bp", 2, 50);
        byte_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 byte_ready = 1'b1;
        wait_done("bp", 200);
        check("bp_nbytes", got_bytes.size(), 8);
        check("bp_b2", got_bytes[2], 8'hB2);
        check("bp_b3", got_bytes[3], 8'hA1);
        check("bp_b4", got_bytes[4], 8'h44);
        check("bp_cs_count", cs_count, 2);

        // synaptic address wrap
        start_burst(1'b0, 13'h1FFF, 14'd2);
        wait_done("synwrap", 200);
        check("synwrap_a0", cs_addrs[0], 8191);
        check("synwrap_a1", cs_addrs[1], 0);
        check("synwrap_b0", got_bytes[0], 8'h0D);
        check("synwrap_b4", got_bytes[4], 8'h67);

        // neuron address wrap
        start_burst(1'b1, 13'h00FF, 14'd2);
        wait_done("neurwrap", 300);
        check("neurwrap_a0", cs_addrs[0], 255);
        check("neurwrap_a1", cs_addrs[1], 0);
        check("neurwrap_nbytes", got_bytes.size(), 32);
        check("neurwrap_b16", got_bytes[16], 8'hFF);

        // zero-length request
        start_burst(1'b0, 13'h0041, 14'd0);
        wait_done("zero", 20);
        check("zero_done_latency", t_done - t_acc, 1);
        check("zero_cs_count", cs_count, 0);

        // abort while emitting
        start_burst(1'b0, 13'h0041, 14'd2);
        wait_bytes("abort", 1, 50);
        byte_ready = 1'b0;
        abort_i    = 1'b1;
        @(posedge clk); #1;
        abort_i    = 1'b0;
        byte_ready = 1'b1;
        @(negedge clk);
        check("abort_valid", BYTE_VALID, 1'b0);
        check("abort_req_ready", REQ_READY, 1'b1);
        check("abort_busy", BUSY, 1'b0);
        repeat (6) @(negedge clk);
        check("abort_no_done", t_done, -1);
        check("abort_cs_count", cs_count, 1);

        // reset in the middle of a burst
        start_burst(1'b0, 13'h0041, 14'd2);
        wait_bytes("rstmid", 3, 50);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_valid", BYTE_VALID, 1'b0);
        check("rstmid_syn_cs", RB_SYNARRAY_CS, 1'b0);
        check("rstmid_done", DONE, 1'b0);
        check("rstmid_req_ready", REQ_READY, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rstmid_no_done", t_done, -1);

        // recovery after reset
        start_burst(1'b1, 13'h0008, 14'd1);
        wait_done("recover", 300);
        check("recover_nbytes", got_bytes.size(), 16);
        check("recover_b5", got_bytes[5], 8'h05);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
